// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: channel tags, FSM states,
// the default busy timeout and small channel helpers.
package tx_arbiter_pkg;

    localparam int BUSY_TIMEOUT_DEF = 15;

    localparam logic [1:0] MOVE_DONE  = 2'd0;
    localparam logic [1:0] SCAN_LEFT  = 2'd1;
    localparam logic [1:0] SCAN_RIGHT = 2'd2;
    localparam logic [1:0] STATUS     = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    function automatic logic [4:0] payload_of(input logic [19:0] p, input logic [1:0] ch);
        case (ch)
            MOVE_DONE:  return p[4:0];
            SCAN_LEFT:  return p[9:5];
            SCAN_RIGHT: return p[14:10];
            STATUS:     return p[19:15];
            default:    return 5'd0;
        endcase
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick4.sv
// Combinational four-way round-robin selector; the search begins one past the
// previous winner and wraps.
module rr_pick4
    import tx_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] grant
);

    logic [1:0] idx_s;

    // first requesting channel at offsets 1..4 from the last winner
    always_comb begin
        valid = 1'b0;
        grant = last;
        idx_s = last;
        for (int i = 1; i <= 4; i++) begin
            idx_s = last + i[1:0];
            if (!valid && req[idx_s]) begin
                valid = 1'b1;
                grant = idx_s;
            end else begin
                valid = valid;
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates four byte producers onto one UART transmitter, with start-pulse
// retry when the transmitter never reports busy.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic [5*NCH-1:0] payload,
    input  logic             TxD_busy,
    output logic             TxD_start,
    output logic [7:0]       TxD_data,
    output logic [NCH-1:0]   ack,
    output logic             err_timeout
);

    localparam int            CW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    arb_state_e     state_r;
    logic [1:0]     last_grant_r;
    logic [1:0]     grant_r;
    logic [CW-1:0]  cnt_r;
    logic           start_r;
    logic [7:0]     data_r;
    logic [NCH-1:0] ack_r;
    logic           err_r;
    logic           pick_valid_s;
    logic [1:0]     pick_s;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_grant_r),
        .valid (pick_valid_s),
        .grant (pick_s)
    );

    // transaction FSM; start and ack default low so each is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= STATUS;
            grant_r      <= MOVE_DONE;
            cnt_r        <= '0;
            start_r      <= 1'b0;
            data_r       <= 8'd0;
            ack_r        <= '0;
            err_r        <= 1'b0;
        end else begin
            start_r <= 1'b0;
            ack_r   <= '0;
            case (state_r)
                IDLE: begin
                    if (!TxD_busy && pick_valid_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        data_r       <= {1'b0, pick_s, payload_of(payload, pick_s)};
                        start_r      <= 1'b1;
                        state_r      <= START;
                    end
                end
                START: begin
                    cnt_r   <= '0;
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (TxD_busy) begin
                        ack_r   <= NCH'(onehot4(grant_r));
                        state_r <= WAIT_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        // start + timeout window gives one re-pulse every BUSY_TIMEOUT+1 cycles
                        err_r   <= 1'b1;
                        start_r <= 1'b1;
                        state_r <= START;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!TxD_busy) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign TxD_start   = start_r;
    assign TxD_data    = data_r;
    assign ack         = ack_r;
    assign err_timeout = err_r;

endmodule
